// File: rtl/alu_staged_n_if.sv
// Controller/bus handshake bundle for alu_staged_n.
// The shared result bus RES stays a plain tri-state port on the ALU.
interface alu_staged_n_if #(
  parameter int WIDTH = 10
);
  logic [WIDTH-1:0] OP;
  logic [3:0]       FN;
  logic             Ain;
  logic             Gin;
  logic             Gout;
  logic [3:0]       Flags;
  logic             Busy;
  logic             Done;

  modport master (output OP, FN, Ain, Gin, Gout, input Flags, Busy, Done);
  modport slave  (input OP, FN, Ain, Gin, Gout, output Flags, Busy, Done);
endinterface

// File: rtl/alu_staged_n.sv
// Staged A/G ALU with Z/N/C/V flags and an optional one-bit-per-cycle shifter.
// All state changes on the falling edge of CLKb; RES is a tri-state bus driver.
module alu_staged_n #(
  parameter int WIDTH      = 10,
  parameter int SHIFT_ITER = 1
) (
  input  logic                CLKb,
  input  logic                Rst,
  alu_staged_n_if.slave       bus,
  output wire  [WIDTH-1:0]    RES
);

  localparam int M     = WIDTH - 1;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] W_ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] W_WID = WIDTH'(WIDTH);
  localparam logic [WIDTH-1:0] W_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_g;
  logic [3:0]         r_flags;
  logic               r_done;
  logic [WIDTH-1:0]   r_work;
  logic [CNT_W-1:0]   r_cnt;
  logic [1:0]         r_sop;
  logic               r_cen;

  logic [WIDTH-1:0]        w_res;
  logic                    w_c;
  logic                    w_v;
  logic                    w_valid;
  logic                    w_is_shift;
  logic [WIDTH:0]          w_sum;
  logic [WIDTH-1:0]        w_tmp;
  logic signed [WIDTH-1:0] w_a_s;
  logic [WIDTH-1:0]        w_sh;
  logic [WIDTH-1:0]        w_step;
  logic                    w_step_c;
  logic                    w_start_iter;
  logic                    w_commit;
  logic                    w_launch;

  function automatic logic [3:0] f_flags(input logic [WIDTH-1:0] r, input logic c,
                                         input logic v);
    return {(r == '0), r[M], c, v};
  endfunction

  // Single-cycle result and flags from the current A and bus operand
  always_comb begin
    w_res      = '0;
    w_c        = 1'b0;
    w_v        = 1'b0;
    w_valid    = 1'b1;
    w_is_shift = 1'b0;
    w_sum      = '0;
    w_tmp      = '0;
    w_a_s      = r_a;
    w_sh       = bus.OP;
    unique case (bus.FN)
      4'b0000, 4'b0001: w_res = bus.OP;
      4'b0010: begin
        w_sum = {1'b0, r_a} + {1'b0, bus.OP};
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (r_a[M] == bus.OP[M]) && (w_res[M] != r_a[M]);
      end
      4'b0011: begin
        w_res = r_a - bus.OP;
        w_c   = (r_a < bus.OP);
        w_v   = (r_a[M] != bus.OP[M]) && (w_res[M] != r_a[M]);
      end
      4'b0100: begin
        w_res = -bus.OP;
        w_c   = (bus.OP != '0);
        w_v   = (bus.OP == W_MIN);
      end
      4'b0101: w_res = ~bus.OP;
      4'b0110: w_res = r_a & bus.OP;
      4'b0111: w_res = r_a | bus.OP;
      4'b1000: w_res = r_a ^ bus.OP;
      4'b1001: begin
        w_is_shift = 1'b1;
        w_res      = r_a << w_sh;
        if (w_sh != '0 && w_sh < W_WID) begin
          w_tmp = r_a << (w_sh - W_ONE);
          w_c   = w_tmp[M];
        end
      end
      4'b1010: begin
        w_is_shift = 1'b1;
        w_res      = r_a >> w_sh;
        if (w_sh != '0 && w_sh < W_WID) begin
          w_tmp = r_a >> (w_sh - W_ONE);
          w_c   = w_tmp[0];
        end
      end
      4'b1011: begin
        w_is_shift = 1'b1;
        w_res      = w_a_s >>> w_sh;
        if (w_sh != '0 && w_sh < W_WID) begin
          w_tmp = r_a >> (w_sh - W_ONE);
          w_c   = w_tmp[0];
        end
      end
      default: w_valid = 1'b0;
    endcase
  end

  // One-bit step of the latched shift; the carry is the bit falling off
  always_comb begin
    w_step   = r_work;
    w_step_c = 1'b0;
    case (r_sop)
      2'b01: begin
        w_step   = {r_work[M-1:0], 1'b0};
        w_step_c = r_work[M];
      end
      2'b10: begin
        w_step   = {1'b0, r_work[M:1]};
        w_step_c = r_work[0];
      end
      default: begin
        w_step   = {r_work[M], r_work[M:1]};
        w_step_c = r_work[0];
      end
    endcase
  end

  assign w_start_iter = (SHIFT_ITER != 0) && w_is_shift && (bus.OP != '0);

  always_comb begin
    w_state_nxt = r_state;
    w_commit    = 1'b0;
    w_launch    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.Gin && w_valid) begin
          if (w_start_iter) begin
            w_launch    = 1'b1;
            w_state_nxt = S_SHIFT;
          end else begin
            w_commit = 1'b1;
          end
        end
      end
      S_SHIFT: begin
        if (r_cnt == CNT_W'(1)) begin
          w_commit    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(negedge CLKb) begin
    if (Rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Datapath registers; the shifter's working copy needs no reset
  always_ff @(negedge CLKb) begin
    if (Rst) begin
      r_a     <= '0;
      r_g     <= '0;
      r_flags <= '0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_done <= w_commit;
      if (r_state == S_IDLE && bus.Ain) r_a <= bus.OP;
      if (w_launch) begin
        r_work <= r_a;
        r_cnt  <= (bus.OP >= W_WID) ? CNT_W'(WIDTH) : bus.OP[CNT_W-1:0];
        r_sop  <= bus.FN[1:0];
        r_cen  <= (bus.OP < W_WID);
      end else if (r_state == S_SHIFT) begin
        r_work <= w_step;
        r_cnt  <= r_cnt - CNT_W'(1);
      end
      if (w_commit) begin
        if (r_state == S_SHIFT) begin
          r_g     <= w_step;
          r_flags <= f_flags(w_step, r_cen & w_step_c, 1'b0);
        end else begin
          r_g     <= w_res;
          r_flags <= f_flags(w_res, w_c, w_v);
        end
      end
    end
  end

  assign bus.Flags = r_flags;
  assign bus.Busy  = (r_state == S_SHIFT);
  assign bus.Done  = r_done;
  assign RES       = bus.Gout ? r_g : {WIDTH{1'bz}};

endmodule

// File: tb/tb_alu_staged_n.sv
// Bench for alu_staged_n: iterative and barrel-shift instances driven in lockstep
// and compared every cycle against a behavioural model, plus directed literal checks.
module tb_alu_staged_n;
  localparam int W = 10;

  logic CLKb = 1'b0;
  logic Rst  = 1'b1;
  always #5 CLKb = ~CLKb;

  alu_staged_n_if #(.WIDTH(W)) bus_i ();
  alu_staged_n_if #(.WIDTH(W)) bus_b ();
  wire [W-1:0] res_i;
  wire [W-1:0] res_b;

  alu_staged_n #(.WIDTH(W), .SHIFT_ITER(1)) dut_i (.CLKb(CLKb), .Rst(Rst), .bus(bus_i), .RES(res_i));
  alu_staged_n #(.WIDTH(W), .SHIFT_ITER(0)) dut_b (.CLKb(CLKb), .Rst(Rst), .bus(bus_b), .RES(res_b));

  int n_vec = 0;
  int n_err = 0;
  bit run = 0;

  bit t_rst, t_ain, t_gin, t_gout;
  int t_op, t_fn;

  int         m_a[2], m_g[2], m_left[2], m_pg[2];
  logic [3:0] m_f[2], m_pf[2];
  bit         m_done[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Result and flags straight from the operation definitions, on plain integers
  task automatic alu_model(input int a, input int op, input int fn, output int r,
                           output logic [3:0] f, output bit ok);
    int sa, sop;
    bit c, v;
    sa = (a >= 512) ? a - 1024 : a;
    sop = (op >= 512) ? op - 1024 : op;
    c = 0; v = 0; ok = 1; r = 0;
    case (fn)
      0, 1: r = op;
      2: begin r = (a + op) % 1024; c = (a + op) >= 1024; v = (sa + sop > 511) || (sa + sop < -512); end
      3: begin r = (a - op + 1024) % 1024; c = a < op; v = (sa - sop > 511) || (sa - sop < -512); end
      4: begin r = (1024 - op) % 1024; c = op != 0; v = op == 512; end
      5: r = 1023 - op;
      6: r = a & op;
      7: r = a | op;
      8: r = a ^ op;
      9: begin
        r = (op >= W) ? 0 : (a << op) % 1024;
        c = (op >= 1 && op < W) ? (((a << op) >> W) & 1) : 0;
      end
      10: begin
        r = a >> op;
        c = (op >= 1 && op < W) ? ((a >> (op - 1)) & 1) : 0;
      end
      11: begin
        r = (sa >>> op) & 1023;
        c = (op >= 1 && op < W) ? ((a >> (op - 1)) & 1) : 0;
      end
      default: ok = 0;
    endcase
    f = {r == 0, r >= 512, c, v};
  endtask

  task automatic model_step(input int d, input bit iter);
    int r;
    logic [3:0] f;
    bit ok;
    if (t_rst) begin
      m_a[d] = 0; m_g[d] = 0; m_f[d] = 0; m_done[d] = 0; m_left[d] = 0;
      return;
    end
    m_done[d] = 0;
    if (m_left[d] > 0) begin
      m_left[d]--;
      if (m_left[d] == 0) begin
        m_g[d] = m_pg[d]; m_f[d] = m_pf[d]; m_done[d] = 1;
      end
    end else begin
      alu_model(m_a[d], t_op, t_fn, r, f, ok);
      if (t_ain) m_a[d] = t_op;
      if (t_gin && ok) begin
        if (iter && t_fn >= 9 && t_fn <= 11 && t_op != 0) begin
          m_left[d] = (t_op < W) ? t_op : W;
          m_pg[d] = r; m_pf[d] = f;
        end else begin
          m_g[d] = r; m_f[d] = f; m_done[d] = 1;
        end
      end
    end
  endtask

  task automatic cyc(input bit rst, input int op, input int fn, input bit ain, input bit gin,
                     input bit gout);
    t_rst = rst; t_op = op; t_fn = fn; t_ain = ain; t_gin = gin; t_gout = gout;
    Rst = rst;
    bus_i.OP = op[W-1:0]; bus_i.FN = fn[3:0]; bus_i.Ain = ain; bus_i.Gin = gin; bus_i.Gout = gout;
    bus_b.OP = op[W-1:0]; bus_b.FN = fn[3:0]; bus_b.Ain = ain; bus_b.Gin = gin; bus_b.Gout = gout;
    @(negedge CLKb);
    model_step(0, 1);
    model_step(1, 0);
    #1;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (bus_i.Busy && n < 40) begin
      cyc(0, 0, 0, 0, 0, 1);
      n++;
    end
    if (n >= 40) begin
      n_vec++; n_err++;
      $display("FAIL busy_timeout: got busy after %0d cycles expected idle", n);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge
  always @(posedge CLKb) begin
    if (run) begin
      chk("busy_i", bus_i.Busy, m_left[0] > 0);
      chk("done_i", bus_i.Done, m_done[0]);
      chk("flags_i", bus_i.Flags, m_f[0]);
      chk("busy_b", bus_b.Busy, m_left[1] > 0);
      chk("done_b", bus_b.Done, m_done[1]);
      chk("flags_b", bus_b.Flags, m_f[1]);
      if (t_gout) begin
        chk("res_i", res_i, m_g[0]);
        chk("res_b", res_b, m_g[1]);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int n, op, fn;
    for (int d = 0; d < 2; d++) begin
      m_a[d] = 0; m_g[d] = 0; m_f[d] = 0; m_done[d] = 0; m_left[d] = 0; m_pg[d] = 0; m_pf[d] = 0;
    end
    cyc(1, 0, 0, 0, 0, 1);
    run = 1;
    cyc(1, 0, 0, 0, 0, 1);
    chk("rst_res_i", res_i, 0);
    chk("rst_res_b", res_b, 0);
    chk("rst_flags", bus_i.Flags, 0);
    chk("rst_busy", bus_i.Busy, 0);
    chk("rst_done", bus_i.Done, 0);

    cyc(0, 'h3FF, 0, 1, 0, 1);
    cyc(0, 'h001, 2, 0, 1, 1);
    chk("add_wrap_res", res_i, 'h000);
    chk("add_wrap_flags", bus_i.Flags, 4'b1010);
    chk("add_wrap_done", bus_i.Done, 1);
    cyc(0, 'h1FF, 0, 1, 0, 1);
    chk("done_pulse_end", bus_i.Done, 0);
    cyc(0, 'h001, 2, 0, 1, 1);
    chk("add_ovf_res", res_i, 'h200);
    chk("add_ovf_flags", bus_i.Flags, 4'b0101);

    cyc(0, 'h005, 0, 1, 0, 1);
    cyc(0, 'h007, 3, 0, 1, 1);
    chk("sub_res", res_i, 'h3FE);
    chk("sub_flags", bus_i.Flags, 4'b0110);

    cyc(0, 'h0F5, 0, 1, 0, 1);
    cyc(0, 3, 9, 0, 1, 1);
    chk("lsl_k_busy", bus_i.Busy, 1);
    chk("lsl_k_oldg", res_i, 'h3FE);
    chk("lsl_bar_res", res_b, 'h3A8);
    chk("lsl_bar_flags", bus_b.Flags, 4'b0110);
    chk("lsl_bar_busy", bus_b.Busy, 0);
    cyc(0, 'h155, 0, 0, 1, 1);
    chk("lsl_k1_busy", bus_i.Busy, 1);
    chk("lsl_k1_oldg", res_i, 'h3FE);
    chk("pass_bar_res", res_b, 'h155);
    cyc(0, 0, 0, 0, 0, 1);
    chk("lsl_k2_busy", bus_i.Busy, 1);
    cyc(0, 0, 0, 0, 0, 1);
    chk("lsl_k3_busy", bus_i.Busy, 0);
    chk("lsl_k3_res", res_i, 'h3A8);
    chk("lsl_k3_flags", bus_i.Flags, 4'b0110);
    chk("lsl_k3_done", bus_i.Done, 1);

    cyc(0, 'h280, 0, 1, 0, 1);
    cyc(0, 2, 11, 0, 1, 1);
    chk("asr2_bar_res", res_b, 'h3A0);
    chk("asr2_bar_flags", bus_b.Flags, 4'b0100);
    wait_idle(n);
    chk("asr2_res", res_i, 'h3A0);
    chk("asr2_flags", bus_i.Flags, 4'b0100);
    cyc(0, 12, 11, 0, 1, 1);
    chk("asr12_bar_res", res_b, 'h3FF);
    chk("asr12_bar_flags", bus_b.Flags, 4'b0100);
    wait_idle(n);
    chk("asr12_busy_cycles", n, 10);
    chk("asr12_res", res_i, 'h3FF);
    chk("asr12_flags", bus_i.Flags, 4'b0100);
    cyc(0, 12, 10, 0, 1, 1);
    chk("lsr12_bar_res", res_b, 'h000);
    chk("lsr12_bar_flags", bus_b.Flags, 4'b1000);
    wait_idle(n);
    chk("lsr12_res", res_i, 'h000);
    chk("lsr12_flags", bus_i.Flags, 4'b1000);

    cyc(0, 'h2AA, 14, 0, 1, 1);
    chk("rsv_res_i", res_i, 'h000);
    chk("rsv_flags_i", bus_i.Flags, 4'b1000);
    chk("rsv_done_i", bus_i.Done, 0);
    chk("rsv_done_b", bus_b.Done, 0);

    cyc(0, 'h123, 0, 1, 1, 1);
    cyc(0, 5, 9, 0, 1, 1);
    chk("abort_busy", bus_i.Busy, 1);
    cyc(1, 0, 0, 0, 0, 1);
    chk("abort_res", res_i, 'h000);
    chk("abort_flags", bus_i.Flags, 0);
    chk("abort_busy_clr", bus_i.Busy, 0);
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, 0, 0, 0, 1);
      chk("abort_no_done", bus_i.Done, 0);
      chk("abort_no_commit", res_i, 'h000);
    end

    for (int i = 0; i < 3000; i++) begin
      fn = $urandom_range(0, 15);
      case ($urandom_range(0, 7))
        0: op = 0;
        1: op = 'h200;
        2: op = 'h3FF;
        3, 4: op = $urandom_range(0, 12);
        default: op = $urandom_range(0, 1023);
      endcase
      cyc($urandom_range(0, 59) == 0, op, fn, $urandom_range(0, 2) == 0,
          $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0);
    end

    @(negedge CLKb);
    run = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
